product_digit_accumulator: RTL and testbench

//  Downstream consumer of multiply_51x51. Accepts a stream of 102-bit products (six 17-bit digits),

---
 rtl/product_digit_accumulator.sv | 148 ++++++++++++++
 tb/tb_product_digit_accumulator.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/product_digit_accumulator.sv
// Accumulates tagged 102-bit products into a redundant digit array, then resolves
// carries digit-serially and streams out normalised digits, least significant first.
module product_digit_accumulator #(
    parameter int DIGIT_W     = 17,
    parameter int PROD_DIGITS = 6,
    parameter int NUM_DIGITS  = 16,
    parameter int GUARD       = 8,
    parameter int OFF_W       = 4
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [DIGIT_W*PROD_DIGITS-1:0] in_prod,
    input  logic [OFF_W-1:0]               in_offset,
    input  logic                           in_last,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [DIGIT_W-1:0]             out_digit,
    output logic [OFF_W-1:0]               out_idx,
    output logic                           out_last,
    output logic [GUARD:0]                 out_carry,
    output logic                           ovf_err
);
    localparam int ACC_W = DIGIT_W + GUARD;
    localparam int CNT_W = GUARD + 1;

    typedef enum logic {ST_ACCUM = 1'b0, ST_DRAIN = 1'b1} state_t;

    state_t             state_q, state_d;
    logic [ACC_W-1:0]   acc_q [NUM_DIGITS];
    logic [ACC_W-1:0]   acc_d [NUM_DIGITS];
    logic [GUARD:0]     carry_q, carry_d;
    logic [OFF_W-1:0]   idx_q, idx_d;
    logic [CNT_W-1:0]   beat_q, beat_d;
    logic               ovf_q, ovf_d;
    logic [OFF_W:0]     pos_s [PROD_DIGITS];
    logic [ACC_W:0]     sum_s;
    logic               drain_s;
    logic               top_s;

    assign drain_s = (state_q == ST_DRAIN);
    assign top_s   = (idx_q == OFF_W'(NUM_DIGITS - 1));
    assign sum_s   = {1'b0, acc_q[0]} + (ACC_W + 1)'(carry_q);

    // Target digit position of each incoming product digit (one extra bit to detect drop-off).
    always_comb begin
        for (int i = 0; i < PROD_DIGITS; i++) begin
            pos_s[i] = {1'b0, in_offset} + (OFF_W + 1)'(i);
        end
    end

    // Next-state logic for the accumulate/drain sequence.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        carry_d = carry_q;
        idx_d   = idx_q;
        beat_d  = beat_q;
        ovf_d   = ovf_q;
        case (state_q)
            ST_ACCUM: begin
                if (in_valid) begin
                    for (int i = 0; i < PROD_DIGITS; i++) begin
                        if (pos_s[i] < (OFF_W + 1)'(NUM_DIGITS)) begin
                            acc_d[pos_s[i][OFF_W-1:0]] = acc_d[pos_s[i][OFF_W-1:0]]
                                + ACC_W'(in_prod[i*DIGIT_W +: DIGIT_W]);
                        end else if (in_prod[i*DIGIT_W +: DIGIT_W] != {DIGIT_W{1'b0}}) begin
                            ovf_d = 1'b1;
                        end else begin
                            ovf_d = ovf_d;
                        end
                    end
                    // Count saturates once the guard bits can no longer be trusted.
                    if (beat_q == CNT_W'(2 ** GUARD)) begin
                        ovf_d = 1'b1;
                    end else begin
                        beat_d = beat_q + CNT_W'(1);
                    end
                    if (in_last) begin
                        state_d = ST_DRAIN;
                        idx_d   = {OFF_W{1'b0}};
                        carry_d = {(GUARD + 1){1'b0}};
                    end else begin
                        state_d = ST_ACCUM;
                    end
                end else begin
                    state_d = ST_ACCUM;
                end
            end
            ST_DRAIN: begin
                if (out_ready) begin
                    if (top_s) begin
                        for (int k = 0; k < NUM_DIGITS; k++) begin
                            acc_d[k] = {ACC_W{1'b0}};
                        end
                        carry_d = {(GUARD + 1){1'b0}};
                        idx_d   = {OFF_W{1'b0}};
                        beat_d  = {CNT_W{1'b0}};
                        state_d = ST_ACCUM;
                    end else begin
                        for (int k = 0; k < NUM_DIGITS - 1; k++) begin
                            acc_d[k] = acc_q[k+1];
                        end
                        acc_d[NUM_DIGITS-1] = {ACC_W{1'b0}};
                        carry_d = sum_s[ACC_W:DIGIT_W];
                        idx_d   = idx_q + OFF_W'(1);
                    end
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            default: begin
                state_d = ST_ACCUM;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_ACCUM;
            for (int k = 0; k < NUM_DIGITS; k++) begin
                acc_q[k] <= {ACC_W{1'b0}};
            end
            carry_q <= {(GUARD + 1){1'b0}};
            idx_q   <= {OFF_W{1'b0}};
            beat_q  <= {CNT_W{1'b0}};
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            carry_q <= carry_d;
            idx_q   <= idx_d;
            beat_q  <= beat_d;
            ovf_q   <= ovf_d;
        end
    end

    assign in_ready  = ~drain_s;
    assign out_valid = drain_s;
    assign out_digit = drain_s ? sum_s[DIGIT_W-1:0] : {DIGIT_W{1'b0}};
    assign out_idx   = drain_s ? idx_q : {OFF_W{1'b0}};
    assign out_last  = drain_s & top_s;
    assign out_carry = drain_s ? sum_s[ACC_W:DIGIT_W] : {(GUARD + 1){1'b0}};
    assign ovf_err   = ovf_q;

endmodule

// File: tb/tb_product_digit_accumulator.sv
// Scoreboard bench for product_digit_accumulator: stimulus pushes expected digits from a
// wide-integer model, a negedge monitor pops and compares on every output handshake.
module tb_product_digit_accumulator;
    logic         clk = 1'b0;
    logic         reset_n;
    logic         in_valid;
    logic         in_ready;
    logic [101:0] in_prod;
    logic [3:0]   in_offset;
    logic         in_last;
    logic         out_valid;
    logic         out_ready;
    logic [16:0]  out_digit;
    logic [3:0]   out_idx;
    logic         out_last;
    logic [8:0]   out_carry;
    logic         ovf_err;

    typedef struct packed {
        logic [16:0] d;
        logic [3:0]  idx;
        logic        last;
        logic [8:0]  c;
    } exp_t;

    exp_t         sb[$];
    logic [101:0] fp[$];
    int           fo[$];
    int           tests = 0;
    int           fails = 0;

    localparam logic [50:0] MAX51 = 51'h7_FFFF_FFFF_FFFF;

    product_digit_accumulator dut (
        .clk(clk), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_prod(in_prod),
        .in_offset(in_offset), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_digit(out_digit),
        .out_idx(out_idx), .out_last(out_last), .out_carry(out_carry),
        .ovf_err(ovf_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [101:0] mul51(input logic [50:0] a, input logic [50:0] b);
        logic [101:0] wa;
        logic [101:0] wb;
        wa = {51'd0, a};
        wb = {51'd0, b};
        return wa * wb;
    endfunction

    // Monitor: one expected entry per accepted output digit.
    always @(negedge clk) begin
        if (reset_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_output", {60'd0, out_idx}, 64'hFFFF);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("digit", {47'd0, out_digit}, {47'd0, e.d});
                chk("idx", {60'd0, out_idx}, {60'd0, e.idx});
                chk("last", {63'd0, out_last}, {63'd0, e.last});
                if (e.last) chk("carry", {55'd0, out_carry}, {55'd0, e.c});
            end
        end
    end

    // Bignum model: sum of products shifted by their digit offsets, dropped digits excluded.
    task automatic push_model();
        logic [289:0] s;
        exp_t e;
        s = '0;
        for (int j = 0; j < fp.size(); j++) begin
            for (int i = 0; i < 6; i++) begin
                if (fo[j] + i < 16) s = s + ({273'd0, fp[j][17*i +: 17]} << (17 * (fo[j] + i)));
            end
        end
        for (int k = 0; k < 16; k++) begin
            e.d    = s[17*k +: 17];
            e.idx  = 4'(k);
            e.last = (k == 15);
            e.c    = (k == 15) ? s[272 +: 9] : 9'd0;
            sb.push_back(e);
        end
    endtask

    task automatic send_beat(input logic [101:0] p, input logic [3:0] off, input logic last);
        int w;
        w = 0;
        in_valid = 1'b1; in_prod = p; in_offset = off; in_last = last;
        while (!in_ready && w < 100) begin
            @(posedge clk); #1; w++;
        end
        if (!in_ready) chk("in_ready_timeout", 64'd0, 64'd1);
        @(posedge clk); #1;
        in_valid = 1'b0; in_last = 1'b0;
    endtask

    task automatic run_frame();
        push_model();
        for (int j = 0; j < fp.size(); j++) send_beat(fp[j], 4'(fo[j]), j == fp.size() - 1);
        fp.delete();
        fo.delete();
    endtask

    task automatic wait_done(input string nm);
        int w;
        w = 0;
        while ((sb.size() != 0 || out_valid) && w < 200) begin
            @(posedge clk); #1; w++;
        end
        chk(nm, {32'd0, sb.size()}, 64'd0);
        chk({nm, "_in_ready"}, {63'd0, in_ready}, 64'd1);
    endtask

    task automatic wait_idx(input logic [3:0] target);
        int w;
        w = 0;
        while (!(out_valid && out_idx == target) && w < 200) begin
            @(posedge clk); #1; w++;
        end
        chk("reach_idx", {60'd0, out_idx}, {60'd0, target});
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [101:0] p;
        logic [16:0]  held_d;
        reset_n = 1'b0; in_valid = 1'b0; in_prod = '0; in_offset = 4'd0;
        in_last = 1'b0; out_ready = 1'b1;
        #1;
        chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_out_digit", {47'd0, out_digit}, 64'd0);
        chk("rst_ovf", {63'd0, ovf_err}, 64'd0);
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;

        // 1: single beat of value 1
        fp.push_back(102'd1); fo.push_back(0);
        run_frame();
        wait_done("t1_done");

        // 2: carry across digit 0
        fp.push_back(102'h1FFFF); fo.push_back(0);
        fp.push_back(102'h00001); fo.push_back(0);
        run_frame();
        wait_done("t2_done");

        // 4: backpressure at idx 4
        fp.push_back(mul51(51'h1234_5678_9ABC, 51'h7_0F0F_0F0F_0F0F)); fo.push_back(2);
        run_frame();
        wait_idx(4'd4);
        out_ready = 1'b0;
        held_d = out_digit;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            chk("bp_digit", {47'd0, out_digit}, {47'd0, held_d});
            chk("bp_idx", {60'd0, out_idx}, 64'd4);
            chk("bp_in_ready", {63'd0, in_ready}, 64'd0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_resume_idx", {60'd0, out_idx}, 64'd5);
        wait_done("t4_done");

        // 5: multiplier-output frames, including a 36-beat frame with top carry
        fp.push_back(mul51(51'd12345, 51'd67890)); fo.push_back(0);
        fp.push_back(mul51(MAX51, 51'h4_0000_0000_0003)); fo.push_back(3);
        run_frame();
        wait_done("t5a_done");
        for (int j = 0; j < 36; j++) begin
            fp.push_back(mul51(MAX51 - 51'(j), MAX51)); fo.push_back(j % 11);
        end
        run_frame();
        wait_done("t5b_done");
        chk("t5_ovf", {63'd0, ovf_err}, 64'd0);

        // 3: digits placed at the top, then one falling off
        for (int i = 0; i < 6; i++) p[17*i +: 17] = 17'h0ABCD;
        fp.push_back(p); fo.push_back(10);
        run_frame();
        wait_done("t3a_done");
        chk("t3a_ovf", {63'd0, ovf_err}, 64'd0);
        for (int i = 0; i < 5; i++) p[17*i +: 17] = 17'h00003;
        p[85 +: 17] = 17'h00001;
        fp.push_back(p); fo.push_back(11);
        run_frame();
        wait_done("t3b_done");
        chk("t3b_ovf", {63'd0, ovf_err}, 64'd1);

        // 6: reset in the middle of a drain
        fp.push_back(mul51(51'h5_5555_5555_5555, 51'h3_3333_3333_3333)); fo.push_back(1);
        run_frame();
        wait_idx(4'd7);
        reset_n = 1'b0;
        #1;
        chk("rst_mid_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_mid_in_ready", {63'd0, in_ready}, 64'd1);
        chk("rst_mid_ovf", {63'd0, ovf_err}, 64'd0);
        sb.delete();
        @(posedge clk); #1;
        reset_n = 1'b1;
        fp.push_back(102'd5); fo.push_back(0);
        run_frame();
        wait_done("t6_done");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
